r5_input_gather: RTL and testbench

//  Upstream stage of the radix-5 butterfly: accepts serial complex IEEE-754 single-precision samples (valid/ready).

---
 rtl/r5_pkg.sv | 20 ++
 rtl/r5_bank.sv | 50 +++++
 rtl/r5_input_gather.sv | 144 ++++++++++++++
 tb/tb_r5_input_gather.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/r5_pkg.sv
// r5_pkg: shared sizes and sample/group types for the radix-5 input gather stage.
package r5_pkg;

    localparam int DW   = 32;                  // float32 word per real/imag part
    localparam int N_PT = 5;                   // points per radix-5 group
    localparam int FW   = $clog2(N_PT);        // fill counter width

    localparam logic [DW-1:0] F32_ZERO = 32'h0000_0000;   // +0.0

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    // Element 0 is the first sample accepted into the group.
    typedef cplx_t [N_PT-1:0] grp_t;

    localparam cplx_t CPLX_ZERO = '{re: F32_ZERO, im: F32_ZERO};

endpackage

// File: rtl/r5_bank.sv
// r5_bank: five-slot complex register bank. Fills one slot per write, closes the
// group on the fifth write or an early-flush write, zero-pads the unfilled tail
// and holds the group (full) until cleared by the consumer.
module r5_bank
    import r5_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  cplx_t         wr_data,
    input  logic          wr_last,
    input  logic          clear,
    output grp_t          grp,
    output logic          full,
    output logic          done,
    output logic [FW-1:0] fill
);

    logic wr_ok;
    logic at_end;

    // A full bank ignores writes so a presented group can never be disturbed.
    assign wr_ok  = wr_en && !full;
    assign at_end = (fill == FW'(N_PT - 1));
    assign done   = wr_ok && (at_end || wr_last);

    // Slot write, tail padding on completion, fill count and full flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp  <= '0;
            fill <= '0;
            full <= 1'b0;
        end else begin
            if (clear)
                full <= 1'b0;
            if (wr_ok) begin
                for (int i = 0; i < N_PT; i++) begin
                    if (FW'(i) == fill)
                        grp[i] <= wr_data;
                    else if (done && (FW'(i) > fill))
                        grp[i] <= CPLX_ZERO;
                end
                fill <= done ? '0 : fill + 1'b1;
                if (done)
                    full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/r5_input_gather.sv
// r5_input_gather: packs serial complex float32 samples into radix-5 groups
// x0..x4 for the butterfly, tracks group position within the FFT frame and
// flags early-flushed (short) groups.
// Build option R5_DOUBLE_BUF_EN: ping-pong banks so one group fills while the
// other is presented (1 sample/clk sustained). Without it a single bank is used
// and input stalls while a group is presented.
module r5_input_gather
    import r5_pkg::*;
#(
    parameter int DW           = 32,
    parameter int FRAME_GROUPS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_re,
    input  logic [DW-1:0] in_img,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] x0_re,
    output logic [DW-1:0] x1_re,
    output logic [DW-1:0] x2_re,
    output logic [DW-1:0] x3_re,
    output logic [DW-1:0] x4_re,
    output logic [DW-1:0] x0_img,
    output logic [DW-1:0] x1_img,
    output logic [DW-1:0] x2_img,
    output logic [DW-1:0] x3_img,
    output logic [DW-1:0] x4_img,
    output logic          out_frame_end,
    output logic          err_short
);

    localparam int IW = (FRAME_GROUPS > 1) ? $clog2(FRAME_GROUPS) : 1;

    cplx_t         wr_data;
    grp_t          grp;
    logic          accept;
    logic          out_hs;
    logic          done;
    logic [FW-1:0] fill;
    logic [IW-1:0] grp_idx;

    assign wr_data = '{re: in_re, im: in_img};
    assign accept  = in_valid && in_ready;
    assign out_hs  = out_valid && out_ready;

`ifdef R5_DOUBLE_BUF_EN
    logic          wr_sel;
    logic          rd_sel;
    logic [1:0]    b_wr;
    logic [1:0]    b_clr;
    logic [1:0]    b_full;
    logic [1:0]    b_done;
    grp_t          b_grp  [2];
    logic [FW-1:0] b_fill [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign b_wr[b]  = accept && (wr_sel == 1'(b));
        assign b_clr[b] = out_hs && (rd_sel == 1'(b));

        r5_bank u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (b_wr[b]),
            .wr_data (wr_data),
            .wr_last (in_last),
            .clear   (b_clr[b]),
            .grp     (b_grp[b]),
            .full    (b_full[b]),
            .done    (b_done[b]),
            .fill    (b_fill[b])
        );
    end

    // The write bank is never the presented full bank, so the write bank being
    // full means both are full.
    assign in_ready  = rst_n && !b_full[wr_sel];
    assign out_valid = b_full[rd_sel];
    assign grp       = b_grp[rd_sel];
    assign done      = |b_done;
    assign fill      = b_fill[wr_sel];

    // Fill pointer advances on completion, present pointer on output handshake;
    // both alternate, so output order equals completion order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (done)
                wr_sel <= !wr_sel;
            if (out_hs)
                rd_sel <= !rd_sel;
        end
    end
`else
    logic full;

    r5_bank u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (wr_data),
        .wr_last (in_last),
        .clear   (out_hs),
        .grp     (grp),
        .full    (full),
        .done    (done),
        .fill    (fill)
    );

    assign out_valid = full;
    assign in_ready  = rst_n && !full;
`endif

    assign out_frame_end = out_valid && (grp_idx == IW'(FRAME_GROUPS - 1));

    // Frame position of the presented group, and the short-group pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grp_idx   <= '0;
            err_short <= 1'b0;
        end else begin
            err_short <= done && (fill != FW'(N_PT - 1));
            if (out_hs)
                grp_idx <= (grp_idx == IW'(FRAME_GROUPS - 1)) ? '0 : grp_idx + 1'b1;
        end
    end

    assign x0_re  = grp[0].re;
    assign x1_re  = grp[1].re;
    assign x2_re  = grp[2].re;
    assign x3_re  = grp[3].re;
    assign x4_re  = grp[4].re;
    assign x0_img = grp[0].im;
    assign x1_img = grp[1].im;
    assign x2_img = grp[2].im;
    assign x3_img = grp[3].im;
    assign x4_img = grp[4].im;

endmodule

// File: tb/tb_r5_input_gather.sv
// tb_r5_input_gather: directed plus randomized stimulus against a queue-based
// group model; honours R5_DOUBLE_BUF_EN for the buffering depth.
module tb_r5_input_gather;

    localparam int FG = 5;
`ifdef R5_DOUBLE_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_re;
    logic [31:0] in_img;
    logic        in_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] x0_re, x1_re, x2_re, x3_re, x4_re;
    logic [31:0] x0_img, x1_img, x2_img, x3_img, x4_img;
    logic        out_frame_end;
    logic        err_short;

    r5_input_gather #(.DW(32), .FRAME_GROUPS(FG)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_re         (in_re),
        .in_img        (in_img),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .x0_re         (x0_re),
        .x1_re         (x1_re),
        .x2_re         (x2_re),
        .x3_re         (x3_re),
        .x4_re         (x4_re),
        .x0_img        (x0_img),
        .x1_img        (x1_img),
        .x2_img        (x2_img),
        .x3_img        (x3_img),
        .x4_img        (x4_img),
        .out_frame_end (out_frame_end),
        .err_short     (err_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [319:0] q[$];         // completed groups awaiting output, oldest first
    logic [63:0]  part[$];      // samples of the group being gathered
    int           idx = 0;      // frame position of the oldest queued group
    bit           exp_short = 0;
    bit           mon_en = 0;
    bit           prev_stall = 0;
    logic [319:0] prev_grp;
    logic         prev_fe;
    int           fe_cnt = 0;
    int           drop_cnt = 0;
    bit           rnd_ready = 0;
    bit           ready_force = 1;

    task automatic chk(input string tag, input logic [319:0] act, input logic [319:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [319:0] obs_grp();
        return {x0_re, x0_img, x1_re, x1_img, x2_re, x2_img,
                x3_re, x3_img, x4_re, x4_img};
    endfunction

    // Consumer side: fixed level or random back-pressure.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Model: checks observable state, then applies the handshakes of the coming edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [319:0] g;
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, rst_n && (q.size() < CAP));
            chk("frame_end", out_frame_end, (q.size() > 0) && (idx == FG - 1));
            chk("err_short", err_short, exp_short);
            exp_short = 0;
            if (prev_stall) begin
                chk("hold_grp", obs_grp(), prev_grp);
                chk("hold_fe", out_frame_end, prev_fe);
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_grp   = obs_grp();
            prev_fe    = out_frame_end;
            if (rst_n && in_valid && !in_ready)
                drop_cnt++;
            if (!rst_n) begin
                q.delete();
                part.delete();
                idx = 0;
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    chk("grp", obs_grp(), q[0]);
                    if (out_frame_end)
                        fe_cnt++;
                    void'(q.pop_front());
                    idx = (idx + 1) % FG;
                end
                if (in_valid && in_ready) begin
                    part.push_back({in_re, in_img});
                    if (part.size() == 5 || in_last) begin
                        g = '0;
                        for (int i = 0; i < part.size(); i++)
                            g[319 - 64*i -: 64] = part[i];
                        exp_short = (part.size() < 5);
                        q.push_back(g);
                        part.delete();
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
        bit acc = 0;
        int t = 0;
        in_valid = 1'b1;
        in_re    = re;
        in_img   = im;
        in_last  = last;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc)
            chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 1000) begin
            idle(1);
            t++;
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
    endtask

    logic [31:0] fv [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                            32'h4080_0000, 32'h40A0_0000};

    initial begin
        int k;
        in_valid = 1'b0;
        in_re    = '0;
        in_img   = '0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        idle(3);
        rst_n  = 1'b1;
        mon_en = 1;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_x0_re", x0_re, 0);
        chk("rst_x4_img", x4_img, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_frame_end", out_frame_end, 0);
        @(posedge clk);
        #1;

        // 1: full group 1.0..5.0, im = -re
        for (int i = 0; i < 5; i++)
            send(fv[i], fv[i] | 32'h8000_0000, 1'b0);
        @(negedge clk);
        chk("t1_valid", out_valid, 1);
        chk("t1_x0_re", x0_re, 32'h3F80_0000);
        chk("t1_x4_re", x4_re, 32'h40A0_0000);
        chk("t1_x4_img", x4_img, 32'hC0A0_0000);
        @(posedge clk);
        #1;
        drain();

        // 2: short group flushed on the 3rd sample
        for (int i = 0; i < 3; i++)
            send(fv[i], fv[i] | 32'h8000_0000, i == 2);
        @(negedge clk);
        chk("t2_err_short", err_short, 1);
        chk("t2_x2_re", x2_re, 32'h4040_0000);
        chk("t2_x3_re", x3_re, 0);
        chk("t2_x4_img", x4_img, 0);
        @(posedge clk);
        #1;
        drain();
        for (int i = 0; i < 5; i++)
            send(fv[4 - i], fv[i], 1'b0);
        drain();

        // 3: output stalled for 10 clocks with input pressure
        ready_force = 0;
        for (int i = 0; i < 5; i++)
            send(32'h4100_0000 + i, 32'h4200_0000 + i, 1'b0);
        k = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_re    = 32'h4300_0000 + k;
            in_img   = k;
            @(negedge clk);
            if (in_ready)
                k++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("t3_accepted", k, (CAP == 2) ? 5 : 0);
        ready_force = 1;
        idle(2);
        drain();

        // 4: one frame plus one group back-to-back from reset
        do_reset();
        fe_cnt   = 0;
        drop_cnt = 0;
        for (int i = 0; i < 30; i++)
            send($urandom, $urandom, 1'b0);
        drain();
        chk("t4_frame_ends", fe_cnt, 1);
`ifdef R5_DOUBLE_BUF_EN
        chk("t4_no_stall", drop_cnt, 0);
`endif

        // 5: reset mid-group discards it
        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++)
            send(fv[i], 32'h5000_0000 + i, 1'b0);
        drain();

        // 6: random stalls on both sides with random early flushes
        rnd_ready = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3));
            send($urandom, $urandom, $urandom_range(0, 7) == 0);
        end
        rnd_ready = 0;
        idle(2);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
